imem_loader: RTL and testbench

- Program loader that writes instruction memory. It is the write-side counterpart of the core's instruction-fetch read path.
- It accepts a framed byte stream from a host link and assembles little-endian 32-bit instruction words. It issues one-cycle write strobes to the instruction memory.
- It holds the core disabled until a frame has loaded and its checksum has verified.
- It sits between the host byte interface and the instruction memory write port, and drives the core's global enable.

---
 rtl/imem_loader_if.sv | 32 +++
 rtl/imem_loader.sv | 156 +++++++++++++++
 tb/tb_imem_loader.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Host byte stream and instruction-memory write port of the program loader.
// Groups the loader's handshake and bus signals so the loader and its host can share one bundle.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  // Valid/ready: the host holds byteIn stable while byteValid is high. A byte is
  // consumed on any rising edge where byteValid & byteReady; it is never consumed otherwise.
  // byteReady depends only on loader state, never on byteValid.
  logic              start;
  logic [7:0]        byteIn;
  logic              byteValid;
  logic              byteReady;
  logic [ADDR_W-1:0] imemWrAddr;
  logic [31:0]       imemWrData;
  logic              imemWren;
  logic              coreEnable;
  logic              busy;
  logic              done;
  logic              error;

  modport slave (
    input  start, byteIn, byteValid,
    output byteReady, imemWrAddr, imemWrData, imemWren,
    output coreEnable, busy, done, error
  );

  modport master (
    output start, byteIn, byteValid,
    input  byteReady, imemWrAddr, imemWrData, imemWren,
    input  coreEnable, busy, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// Framed byte-stream loader: assembles little-endian words, writes instruction memory
// and releases the core only after the frame checksum verifies.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  imem_loader_if.slave     bus,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        lane_q;
  logic [23:0]       asm_q;
  logic [ADDR_W-1:0] words_left_q;
  logic [ADDR_W-1:0] word_addr_q;
  logic [7:0]        csum_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;
  logic              wren_q;
  logic              core_en_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;

  logic              ready;
  logic              accept;
  logic              frame_start;
  logic              word_done;
  logic              csum_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ready       = 1'b0;
    frame_start = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.start) begin
          frame_start = 1'b1;
          state_d     = S_LEN;
        end
      end
      S_LEN: begin
        ready = 1'b1;
        if (bus.byteValid) state_d = S_DATA;
      end
      S_DATA: begin
        ready = 1'b1;
        if (bus.byteValid && lane_q == 2'd3 && words_left_q == '0) state_d = S_CSUM;
      end
      S_CSUM: begin
        ready = 1'b1;
        if (bus.byteValid) state_d = csum_ok ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign accept    = bus.byteValid & ready;
  assign word_done = accept && (state_q == S_DATA) && (lane_q == 2'd3);
  assign csum_ok   = (bus.byteIn == csum_q);

  // Datapath and sticky status. The strobe is simply the registered 4th-byte accept,
  // so it lasts exactly one cycle and is dropped if reset arrives first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane_q       <= 2'd0;
      asm_q        <= 24'd0;
      words_left_q <= '0;
      word_addr_q  <= '0;
      csum_q       <= 8'd0;
      wr_addr_q    <= '0;
      wr_data_q    <= 32'd0;
      wren_q       <= 1'b0;
      core_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      wren_q <= word_done;
      if (frame_start) begin
        lane_q       <= 2'd0;
        words_left_q <= '0;
        word_addr_q  <= '0;
        csum_q       <= 8'd0;
        core_en_q    <= 1'b0;
        busy_q       <= 1'b1;
        done_q       <= 1'b0;
        error_q      <= 1'b0;
      end
      if (accept) begin
        case (state_q)
          S_LEN: begin
            words_left_q <= ADDR_W'(bus.byteIn);
            csum_q       <= bus.byteIn;
          end
          S_DATA: begin
            csum_q <= csum_q ^ bus.byteIn;
            lane_q <= lane_q + 2'd1;
            case (lane_q)
              2'd0: asm_q[7:0]   <= bus.byteIn;
              2'd1: asm_q[15:8]  <= bus.byteIn;
              2'd2: asm_q[23:16] <= bus.byteIn;
              default: begin
                // Top byte bypasses the assembly register straight into the write word.
                wr_data_q   <= {bus.byteIn, asm_q};
                wr_addr_q   <= word_addr_q;
                word_addr_q <= word_addr_q + 1'b1;
                if (words_left_q != '0) words_left_q <= words_left_q - 1'b1;
              end
            endcase
          end
          S_CSUM: begin
            busy_q <= 1'b0;
            if (csum_ok) begin
              done_q    <= 1'b1;
              core_en_q <= 1'b1;
            end else begin
              error_q   <= 1'b1;
              core_en_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.byteReady  = ready;
  assign bus.imemWrAddr = wr_addr_q;
  assign bus.imemWrData = wr_data_q;
  assign bus.imemWren   = wren_q;
  assign bus.coreEnable = core_en_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed-plus-random bench for imem_loader: frames are built from word lists,
// and every expected write and status bit comes from the frame rules, not the RTL.
module tb_imem_loader;
  localparam int ADDR_W = 8;
  localparam int AW1    = ADDR_W + 32;

  logic       clk;
  logic       reset;
  logic [2:0] state_dbg;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int last4_cyc  = 0;
  int strobes    = 0;

  logic [AW1-1:0] exp_q[$];
  logic [31:0]    words[256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // scoreboard: every strobe must match the next expected (addr, data) and arrive
  // the cycle after the accept of that word's 4th byte
  always @(negedge clk) begin
    cyc++;
    if (bus.imemWren === 1'b1) begin
      logic [AW1-1:0] e;
      strobes++;
      compared++;
      assert (exp_q.size() != 0) else begin
        mismatched++;
        $error("FAIL extra_strobe observed addr=%h data=%h expected no write", bus.imemWrAddr, bus.imemWrData);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(bus.imemWrAddr), 32'(e[AW1-1:32]));
        check("wr_data", bus.imemWrData, e[31:0]);
        check("wren_latency", cyc, last4_cyc + 1);
      end
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      int k;
      k = $urandom_range(0, 2);
      repeat (k) begin
        @(negedge clk);
        bus.start     = 1'b0;
        bus.byteValid = 1'b0;
      end
    end
    @(negedge clk);
    bus.start     = 1'b0;
    bus.byteValid = 1'b1;
    bus.byteIn    = b;
    n = 0;
    while (bus.byteReady !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      compared++;
      mismatched++;
      $error("FAIL byte_timeout observed byteReady=%b expected 1", bus.byteReady);
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic start_frame();
    @(negedge clk);
    bus.byteValid = 1'b0;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("start_busy", 32'(bus.busy), 32'd1);
    check("start_done", 32'(bus.done), 32'd0);
    check("start_err", 32'(bus.error), 32'd0);
    check("start_core", 32'(bus.coreEnable), 32'd0);
  endtask

  // Sends LEN, payload from words[0..nw-1] and CSUM^csum_xor; start_at < 0 means no
  // mid-frame start pulse, otherwise start is pulsed before that payload byte index.
  task automatic send_frame(input int nw, input bit gaps, input logic [7:0] csum_xor, input int start_at);
    logic [7:0] cs;
    logic [7:0] b;
    bit         bad;
    cs = 8'(nw - 1);
    send_byte(cs, gaps);
    for (int i = 0; i < nw; i++) begin
      exp_q.push_back({ADDR_W'(i), words[i]});
      for (int j = 0; j < 4; j++) begin
        if (start_at == i * 4 + j) begin
          @(negedge clk);
          bus.byteValid = 1'b0;
          bus.start     = 1'b1;
          @(posedge clk);
        end
        b  = words[i][8*j +: 8];
        cs = cs ^ b;
        send_byte(b, gaps);
        if (j == 3) last4_cyc = cyc;
      end
    end
    send_byte(cs ^ csum_xor, gaps);
    @(negedge clk);
    bus.byteValid = 1'b0;
    bad = (csum_xor != 8'h00);
    check("end_done", 32'(bus.done), bad ? 32'd0 : 32'd1);
    check("end_error", 32'(bus.error), bad ? 32'd1 : 32'd0);
    check("end_core", 32'(bus.coreEnable), bad ? 32'd0 : 32'd1);
    check("end_busy", 32'(bus.busy), 32'd0);
    check("end_pending_writes", exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 32'(bus.byteReady), 32'd0);
    check({tag, "_wren"}, 32'(bus.imemWren), 32'd0);
    check({tag, "_core"}, 32'(bus.coreEnable), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_error"}, 32'(bus.error), 32'd0);
    check({tag, "_addr"}, 32'(bus.imemWrAddr), 32'd0);
    check({tag, "_data"}, bus.imemWrData, 32'd0);
  endtask

  initial begin
    int s0;
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.byteValid = 1'b0;
    bus.byteIn    = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // single word, back-to-back bytes; CSUM 0x82
    words[0] = 32'h01100093;
    start_frame();
    send_frame(1, 1'b0, 8'h00, -1);

    // bytes offered while DONE are not consumed
    @(negedge clk);
    bus.byteValid = 1'b1;
    bus.byteIn    = 8'h5A;
    repeat (3) @(negedge clk);
    check("done_ignore_ready", 32'(bus.byteReady), 32'd0);
    check("done_ignore_done", 32'(bus.done), 32'd1);
    bus.byteValid = 1'b0;

    // two words with random gaps
    words[0] = 32'h00D00093;
    words[1] = 32'h00A00113;
    start_frame();
    send_frame(2, 1'b1, 8'h00, -1);

    // bad checksum 0x83: write still happens, error sticky
    words[0] = 32'h01100093;
    start_frame();
    send_frame(1, 1'b0, 8'h01, -1);
    repeat (2) @(negedge clk);
    check("err_sticky", 32'(bus.error), 32'd1);

    // maximum 256-word frame
    for (int i = 0; i < 256; i++) words[i] = $urandom;
    s0 = strobes;
    start_frame();
    send_frame(256, 1'b0, 8'h00, -1);
    check("max_strobe_count", strobes - s0, 32'd256);

    // reset after the 3rd payload byte: nothing written, outputs back to reset values
    start_frame();
    send_byte(8'h00, 1'b0);
    send_byte(8'h93, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h10, 1'b0);
    @(negedge clk);
    bus.byteValid = 1'b0;
    reset         = 1'b0;
    #1;
    check_reset_vals("midreset");
    @(negedge clk);
    check("midreset_wren", 32'(bus.imemWren), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    words[0] = 32'h01100093;
    start_frame();
    send_frame(1, 1'b0, 8'h00, -1);

    // start pulsed mid-DATA is ignored
    for (int i = 0; i < 3; i++) words[i] = $urandom;
    s0 = strobes;
    start_frame();
    send_frame(3, 1'b1, 8'h00, 6);
    check("midstart_strobes", strobes - s0, 32'd3);

    // random frames: random length, gaps and checksum corruption
    for (int f = 0; f < 6; f++) begin
      int nw;
      logic [7:0] cx;
      nw = $urandom_range(1, 12);
      cx = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      for (int i = 0; i < nw; i++) words[i] = $urandom;
      start_frame();
      send_frame(nw, 1'b1, cx, -1);
    end

    repeat (3) @(negedge clk);
    check("final_pending_writes", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
